fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage between the instruction bus and decode. Owns the architectural fetch PC and drives `ibus_req_t`/`ibus_resp_t` with at most one outstanding request. Delivers `fetch_data_t` (pc, instruction) to decode through a one-entry output register with valid/ready. Handles redirects by flushing the output register and discarding any in-flight response.

## Interface
- `RESET_PC`, default 64'h8000_0000: fetch PC after reset.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `ireq`  out  `ibus_req_t`: `valid`, `addr`; all other fields 0.
- `iresp`  in  `ibus_resp_t`: `addr_ok`, `data_ok`, `data[31:0]`.
- `redirect_valid`  in  1: load a new PC this cycle; branch/jump from later stages.
- `redirect_pc`  in  64: target PC.
- `out_valid`  out  1: `dataF` holds a fetched instruction.
- `out_ready`  in  1: decode accepts `dataF` this cycle.
- `dataF`  out  `fetch_data_t`: `{pc, instruction, misalign}`.

## Operation
- FSM states:
  - IDLE: may issue.
  - HOLD: request presented, `addr_ok` not yet seen.
  - WAIT: address accepted, awaiting `data_ok`.
  - KILL: awaiting `data_ok` of a squashed request.
  - HALT: misalign only.
- `can_issue = (!out_valid || out_ready) && !redirect_valid`.
- `ireq.valid = (IDLE && can_issue) || HOLD`. `ireq.addr = pc`.
- Issue transitions:
  - IDLE with `ireq.valid` and no `addr_ok` → HOLD.
  - `addr_ok` without `data_ok` → WAIT.
  - `addr_ok && data_ok` together → completion, stay IDLE.
- HOLD: `valid` and `addr` stay stable until `addr_ok`, even across a redirect; bus rule, a request is never retracted.
- Completion (`data_ok` in HOLD, WAIT, or the IDLE issue cycle, not squashed):
  - Output register ← `{pc, iresp.data, 0}`; `out_valid` ← 1.
  - `pc` ← `pc + 4` (64-bit, wraps modulo 2^64).
  - Next state IDLE.
- Redirect (`redirect_valid==1`, highest priority):
  - `pc` ← `redirect_pc`; `out_valid` ← 0.
  - In HOLD or WAIT, the outstanding request is marked squashed: HOLD continues until `addr_ok`, then goes to KILL (or straight to IDLE if `data_ok` arrives in the same cycle). WAIT → KILL.
  - KILL: on `data_ok`, discard the data and go to IDLE; `pc` is not incremented.
  - A redirect in KILL only updates `pc`.
- Output register drain: when `out_valid && out_ready` and no completion this cycle, `out_valid` ← 0.
- Completion and drain in the same cycle: the register is overwritten and `out_valid` stays 1.

## Timing
- During reset: `ireq.valid=0`, `ireq.addr=RESET_PC`, `out_valid=0`, `dataF=0`, state IDLE, `pc=RESET_PC`.
- First request is presented in the first cycle after reset deasserts.
- Zero-wait bus (`addr_ok` and `data_ok` in the issue cycle): `out_valid` rises the next cycle. Throughput is 1 instruction/cycle while `out_ready=1`.
- Bus with N-cycle `data_ok` delay: latency N+1 cycles.
- Redirect: the new PC is presented on `ireq.addr` the cycle after `redirect_valid` if the FSM is then in IDLE.
- Reset asserted mid-transaction: immediate return to reset state. A stale `data_ok` arriving after reset is ignored, because in IDLE `data_ok` only counts in a cycle where `ireq.valid && addr_ok`.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - In IDLE with `pc[1:0]!=0` and `can_issue`: no bus request is issued.
  - Output register ← `{pc, 32'h0, 1}`; state → HALT.
  - HALT issues nothing; only a redirect leaves it (→ IDLE).
- Undefined: no check; `misalign` tied 0; `pc` is sent as-is; HALT is absent.

## Structure
- `fetch_data_t` (adds the `misalign` bit) and `fetch_state_t` enum belong in `pipes`.
- `ibus_req_t`, `ibus_resp_t` and `u64` come from `common`.
- One sub-module: `fetch_buf`, the one-entry output register with write/drain/flush.

## Test plan
- Reset release, zero-wait bus returning 32'h00000013: `ireq.addr` = 0x8000_0000, 0x8000_0004, …; `out_valid` from cycle 2; `dataF.pc` increments by 4 each cycle.
- `out_ready=0` for 3 cycles with the buffer full: `ireq.valid=0` throughout and `dataF` held; on release, the next fetch issues the same cycle.
- `addr_ok` delayed 2 cycles, redirect to 0x8000_0100 in the first of them: `ireq.addr` held at its original value until `addr_ok`; that response is discarded; next request goes to 0x8000_0100.
- `data_ok` delayed 3 cycles, redirect in WAIT: `out_valid` goes 0 the next cycle; the stale data never appears on `dataF`; fetch resumes at the redirect PC.
- Reset asserted during WAIT with `data_ok` arriving the next cycle: outputs return to reset values; the stale data is not captured.
- With `FETCH_MISALIGN_CHK_EN`, redirect to 0x8000_0002: no bus request; `dataF={0x8000_0002, 0, 1}`; stays in HALT until a redirect to 0x8000_0000 resumes normal fetch.

Source files
------------

// File: rtl/common.sv
// Shared bus types and scalar aliases used across the core.
package common;

    typedef logic [63:0] u64;

    typedef struct packed {
        logic       valid;
        u64         addr;
        logic [2:0] size;
        logic       cache;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/fetch_unit_pkg.sv
// Fetch-stage constants and PC helpers.
package fetch_unit_pkg;

    import common::*;

    localparam u64 RESET_PC_DEF = 64'h8000_0000;

    function automatic u64 pc_incr(input u64 pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/pipes.sv
// Inter-stage bundles and stage state encodings.
package pipes;

    import common::*;

    typedef enum logic [2:0] {
        F_IDLE,
        F_HOLD,
        F_WAIT,
        F_KILL,
        F_HALT
    } fetch_state_t;

    typedef struct packed {
        u64          pc;
        logic [31:0] instruction;
        logic        misalign;
    } fetch_data_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// One-entry fetch output register: flush beats write beats drain.
module fetch_unit_buf
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush,
    input  logic        i_wr,
    input  fetch_data_t i_wdata,
    input  logic        i_drain,
    output logic        o_valid,
    output fetch_data_t o_data
);

    logic        r_valid;
    fetch_data_t r_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_data  <= i_wdata;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage, one outstanding ibus request.
// Optional misaligned-PC halt: define FETCH_MISALIGN_CHK_EN.
module fetch_unit
    import common::*;
    import pipes::*;
    import fetch_unit_pkg::*;
#(
    parameter u64 RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  u64          redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t dataF
);

    fetch_state_t r_state;
    u64           r_pc;
    u64           r_addr;
    logic         r_squash;

    logic        w_can_issue;
    logic        w_mis;
    logic        w_issue;
    logic        w_cmpl;
    logic        w_sq;
    fetch_data_t w_wdata;

    assign w_can_issue = (!out_valid || out_ready) && !redirect_valid;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_mis = (r_state == F_IDLE) && w_can_issue
                && (r_pc[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_issue = (r_state == F_IDLE) && w_can_issue && !w_mis;
    assign w_sq    = r_squash || redirect_valid;

    // Squashed responses never reach the output register.
    assign w_cmpl = !redirect_valid && (
        (w_issue && iresp.addr_ok && iresp.data_ok) ||
        ((r_state == F_HOLD) && !r_squash
            && iresp.addr_ok && iresp.data_ok) ||
        ((r_state == F_WAIT) && iresp.data_ok));

    always_comb begin
        ireq       = '0;
        ireq.valid = reset && (w_issue || (r_state == F_HOLD));
        ireq.addr  = (r_state == F_HOLD) ? r_addr : r_pc;
    end

    always_comb begin
        w_wdata             = '0;
        w_wdata.pc          = r_pc;
        w_wdata.instruction = w_mis ? 32'h0 : iresp.data;
        w_wdata.misalign    = w_mis;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= F_IDLE;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_squash <= 1'b0;
        end else begin
            if (redirect_valid)
                r_pc <= redirect_pc;
            else if (w_cmpl)
                r_pc <= pc_incr(r_pc);

            unique case (r_state)
                F_IDLE: begin
                    if (w_issue) begin
                        if (!iresp.addr_ok) begin
                            r_state  <= F_HOLD;
                            r_addr   <= r_pc;
                            r_squash <= 1'b0;
                        end else if (!iresp.data_ok) begin
                            r_state <= F_WAIT;
                        end
                    end else if (w_mis) begin
                        r_state <= F_HALT;
                    end
                end
                F_HOLD: begin
                    // The bus never sees a retracted request.
                    if (iresp.addr_ok) begin
                        r_squash <= 1'b0;
                        if (iresp.data_ok)
                            r_state <= F_IDLE;
                        else
                            r_state <= w_sq ? F_KILL : F_WAIT;
                    end else begin
                        r_squash <= w_sq;
                    end
                end
                F_WAIT: begin
                    if (iresp.data_ok)
                        r_state <= F_IDLE;
                    else if (redirect_valid)
                        r_state <= F_KILL;
                end
                F_KILL: begin
                    if (iresp.data_ok)
                        r_state <= F_IDLE;
                end
`ifdef FETCH_MISALIGN_CHK_EN
                F_HALT: begin
                    if (redirect_valid)
                        r_state <= F_IDLE;
                end
`endif
                default: r_state <= F_IDLE;
            endcase
        end
    end

    fetch_unit_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_wr    (w_cmpl || w_mis),
        .i_wdata (w_wdata),
        .i_drain (out_valid && out_ready),
        .o_valid (out_valid),
        .o_data  (dataF)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    import common::*;
    import pipes::*;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    u64          redirect_pc;
    logic        out_valid;
    logic        out_ready;
    fetch_data_t dataF;

    int n_cmp;
    int n_err;

    fetch_unit #(.RESET_PC(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dataF          (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ibus_resp_t rsp(input logic a, input logic d,
                                       input logic [31:0] x);
        ibus_resp_t r;
        r.addr_ok = a;
        r.data_ok = d;
        r.data    = x;
        return r;
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b0;
        iresp          = rsp(1'b0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b1;

        repeat (3) nxt();
        #1;
        chk("rst_ivalid", 64'(ireq.valid), 64'd0);
        chk("rst_iaddr", ireq.addr, 64'h8000_0000);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_pc", dataF.pc, 64'h0);
        chk("rst_instr", 64'(dataF.instruction), 64'h0);

        // zero-wait streaming
        nxt();
        reset = 1'b1;
        iresp = rsp(1'b1, 1'b1, 32'h0000_0013);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("zw_ivalid", 64'(ireq.valid), 64'd1);
            chk("zw_iaddr", ireq.addr, 64'h8000_0000 + 64'(4 * k));
            if (k > 0) begin
                chk("zw_ovalid", 64'(out_valid), 64'd1);
                chk("zw_pc", dataF.pc, 64'h8000_0000 + 64'(4 * (k - 1)));
                chk("zw_instr", 64'(dataF.instruction), 64'h13);
                chk("zw_mis", 64'(dataF.misalign), 64'd0);
            end
            nxt();
        end

        // backpressure with full buffer
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ivalid", 64'(ireq.valid), 64'd0);
            chk("bp_ovalid", 64'(out_valid), 64'd1);
            chk("bp_pc", dataF.pc, 64'h8000_0010);
            nxt();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ivalid", 64'(ireq.valid), 64'd1);
        chk("bp_rel_iaddr", ireq.addr, 64'h8000_0014);
        nxt();

        // addr_ok delayed, redirect while holding
        iresp = rsp(1'b0, 1'b0, 32'h0);
        #1;
        chk("ho_iaddr0", ireq.addr, 64'h8000_0018);
        chk("ho_pc_prev", dataF.pc, 64'h8000_0014);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        #1;
        chk("ho_ivalid1", 64'(ireq.valid), 64'd1);
        chk("ho_iaddr1", ireq.addr, 64'h8000_0018);
        nxt();
        redirect_valid = 1'b0;
        iresp          = rsp(1'b1, 1'b0, 32'h0);
        #1;
        chk("ho_ivalid2", 64'(ireq.valid), 64'd1);
        chk("ho_iaddr2", ireq.addr, 64'h8000_0018);
        chk("ho_ovalid2", 64'(out_valid), 64'd0);
        nxt();
        iresp = rsp(1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("ho_kill_ivalid", 64'(ireq.valid), 64'd0);
        nxt();
        iresp = rsp(1'b1, 1'b1, 32'h0010_0093);
        #1;
        chk("ho_ovalid4", 64'(out_valid), 64'd0);
        chk("ho_new_ivalid", 64'(ireq.valid), 64'd1);
        chk("ho_new_iaddr", ireq.addr, 64'h8000_0100);
        nxt();

        // data_ok delayed, redirect in WAIT
        iresp = rsp(1'b1, 1'b0, 32'h0);
        #1;
        chk("wt_ovalid", 64'(out_valid), 64'd1);
        chk("wt_pc", dataF.pc, 64'h8000_0100);
        chk("wt_instr", 64'(dataF.instruction), 64'h0010_0093);
        chk("wt_iaddr", ireq.addr, 64'h8000_0104);
        nxt();
        iresp = rsp(1'b0, 1'b0, 32'h0);
        #1;
        chk("wt_ivalid", 64'(ireq.valid), 64'd0);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        nxt();
        redirect_valid = 1'b0;
        iresp          = rsp(1'b0, 1'b1, 32'hCAFE_BABE);
        #1;
        chk("wt_ovalid_rd", 64'(out_valid), 64'd0);
        chk("wt_kill_ivalid", 64'(ireq.valid), 64'd0);
        nxt();
        iresp = rsp(1'b1, 1'b1, 32'h0020_0093);
        #1;
        chk("wt_stale_ov", 64'(out_valid), 64'd0);
        chk("wt_new_iaddr", ireq.addr, 64'h8000_0200);
        chk("wt_new_ivalid", 64'(ireq.valid), 64'd1);
        nxt();
        #1;
        chk("wt_res_pc", dataF.pc, 64'h8000_0200);
        chk("wt_res_instr", 64'(dataF.instruction), 64'h0020_0093);

        // reset during WAIT, stale data_ok afterwards
        iresp = rsp(1'b1, 1'b0, 32'h0);
        nxt();
        reset = 1'b0;
        iresp = rsp(1'b0, 1'b0, 32'h0);
        #1;
        chk("mr_ivalid", 64'(ireq.valid), 64'd0);
        nxt();
        reset = 1'b1;
        iresp = rsp(1'b0, 1'b1, 32'hBAD0_BAD0);
        #1;
        chk("mr_ovalid", 64'(out_valid), 64'd0);
        chk("mr_pc", dataF.pc, 64'h0);
        chk("mr_instr", 64'(dataF.instruction), 64'h0);
        chk("mr_iaddr", ireq.addr, 64'h8000_0000);
        nxt();
        iresp = rsp(1'b1, 1'b1, 32'h0000_0013);
        #1;
        chk("mr_hold_ivalid", 64'(ireq.valid), 64'd1);
        chk("mr_hold_ov", 64'(out_valid), 64'd0);
        nxt();
        #1;
        chk("mr_done_ov", 64'(out_valid), 64'd1);
        chk("mr_done_pc", dataF.pc, 64'h8000_0000);
        chk("mr_done_instr", 64'(dataF.instruction), 64'h13);

`ifdef FETCH_MISALIGN_CHK_EN
        iresp          = rsp(1'b0, 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0002;
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk("ma_ivalid0", 64'(ireq.valid), 64'd0);
        nxt();
        #1;
        chk("ma_ivalid1", 64'(ireq.valid), 64'd0);
        chk("ma_ovalid", 64'(out_valid), 64'd1);
        chk("ma_pc", dataF.pc, 64'h8000_0002);
        chk("ma_instr", 64'(dataF.instruction), 64'h0);
        chk("ma_flag", 64'(dataF.misalign), 64'd1);
        nxt();
        #1;
        chk("ma_halt_ivalid", 64'(ireq.valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0000;
        iresp          = rsp(1'b1, 1'b1, 32'h0000_0013);
        nxt();
        redirect_valid = 1'b0;
        #1;
        chk("ma_res_ivalid", 64'(ireq.valid), 64'd1);
        chk("ma_res_iaddr", ireq.addr, 64'h8000_0000);
        nxt();
        #1;
        chk("ma_res_pc", dataF.pc, 64'h8000_0000);
        chk("ma_res_flag", 64'(dataF.misalign), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
